// File: rtl/alu_arbiter.sv
// Purpose : shares one combinational alu between requester 0 (execute stage)
//           and requester 1 (multi-cycle helper) with round-robin arbitration.
// Latency : op accepted at cycle T -> rsp_valid at T+2; at most 1 op / 3 cycles.
// Backpressure: rsp_ready low holds the response stable; no request is accepted
//           until the response has been taken.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake, N = 0,1 (ready is combinational)
//   reqN_control/src1/src2     one-hot op select and operands
//   alu_control/src1/src2      drive the shared alu, non-zero only in EXEC
//   alu_result                 combinational result back from the shared alu
//   rsp_valid / rsp_ready      response handshake
//   rsp_id/result/err          requester id, registered result, not-one-hot flag
module alu_arbiter #(
  parameter int   DATA_W     = 32,
  parameter int   CTRL_W     = 12,
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_control,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic [CTRL_W-1:0] op_control_q;
  logic [DATA_W-1:0] op_src1_q;
  logic [DATA_W-1:0] op_src2_q;
  logic              op_id_q;
  logic              op_err_q;
  logic [DATA_W-1:0] result_q;

  logic              grant0, grant1, accept, winner;
  logic [CTRL_W-1:0] sel_control;
  logic [DATA_W-1:0] sel_src1, sel_src2;
  logic              sel_onehot;

  // Arbitration and next state. A tie goes to the requester that did not win
  // last time. Reset suppresses ready so a requester never sees a handshake
  // that the registers are about to discard.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          if (req0_valid && (!req1_valid || last_grant_q))
            grant0 = 1'b1;
          else if (req1_valid)
            grant1 = 1'b1;
        end
        if (grant0 || grant1)
          state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign winner     = grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_control = winner ? req1_control : req0_control;
  assign sel_src1    = winner ? req1_src1    : req0_src1;
  assign sel_src2    = winner ? req1_src2    : req0_src2;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_onehot  = (sel_control != '0) &&
                       ((sel_control & (sel_control - CTRL_W'(1))) == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ~FIRST_PRIO;
      op_control_q <= '0;
      op_src1_q    <= '0;
      op_src2_q    <= '0;
      op_id_q      <= 1'b0;
      op_err_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_control_q <= sel_control;
        op_src1_q    <= sel_src1;
        op_src2_q    <= sel_src2;
        op_id_q      <= winner;
        op_err_q     <= ~sel_onehot;
        last_grant_q <= winner;
      end
      // Malformed controls still run through the alu slot, but their
      // result is forced to zero so garbage never leaks to the consumer.
      if (state_q == EXEC)
        result_q <= op_err_q ? '0 : alu_result;
    end
  end

  // The shared alu only sees an op during its single EXEC cycle.
  assign alu_control = (state_q == EXEC) ? op_control_q : '0;
  assign alu_src1    = (state_q == EXEC) ? op_src1_q    : '0;
  assign alu_src2    = (state_q == EXEC) ? op_src2_q    : '0;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = op_id_q;
  assign rsp_result = result_q;
  assign rsp_err    = op_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter with a behavioural alu model.
// Latency : checks rsp_valid two cycles after acceptance, held under stall.
// Backpressure: drives rsp_ready low for chosen cycle counts.
module tb_alu_arbiter;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_AND  = 12'h010;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_SRA  = 12'h400;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [11:0] req0_control, req1_control;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [11:0] alu_control;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;

  int vectors     = 0;
  int miscompares = 0;
  bit m_last;  // model of the last granted requester

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // Shared alu: shifts move src2 by src1[4:0]; malformed controls give junk.
  function automatic logic [31:0] alu_fn(logic [11:0] c, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sb;
    sb = b;
    case (c)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12'h008: return (a < b) ? 32'd1 : 32'd0;
      12'h010: return a & b;
      12'h020: return a | b;
      12'h040: return a ^ b;
      12'h080: return ~(a | b);
      12'h100: return b << a[4:0];
      12'h200: return b >> a[4:0];
      12'h400: return sb >>> a[4:0];
      12'h800: return {b[15:0], 16'h0000};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_control, alu_src1, alu_src2);

  function automatic logic [31:0] expect_result(logic [11:0] c, logic [31:0] a, logic [31:0] b);
    return ($countones(c) == 1) ? alu_fn(c, a, b) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_control = '0; req0_src1 = '0; req0_src2 = '0;
    req1_control = '0; req1_src1 = '0; req1_src2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    m_last = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_ctrl", alu_control, 0);
    chk("rst_alu_src", alu_src1 | alu_src2, 0);
  endtask

  // One full transaction: present, accept, EXEC, RESP with `stall` cycles of
  // back-pressure. During EXEC/RESP both valids are raised with junk data and
  // dropped again, which must neither be granted nor disturb round-robin.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [11:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [11:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input int stall, input bit eid, input logic [31:0] eres, input bit eerr);
    @(negedge clk);
    req0_valid = v0; req0_control = c0; req0_src1 = a0; req0_src2 = b0;
    req1_valid = v1; req1_control = c1; req1_src1 = a1; req1_src2 = b1;
    #1;
    chk("req0_ready", req0_ready, eid == 1'b0);
    chk("req1_ready", req1_ready, eid == 1'b1);
    @(posedge clk);
    #1;
    m_last = eid;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_control = 12'h001; req0_src1 = $urandom; req0_src2 = $urandom;
    req1_control = 12'h002; req1_src1 = $urandom; req1_src2 = $urandom;
    @(negedge clk);
    chk("exec_alu_ctrl", alu_control, eid ? c1 : c0);
    chk("exec_alu_src1", alu_src1, eid ? a1 : a0);
    chk("exec_alu_src2", alu_src2, eid ? b1 : b0);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_readies", {req0_ready, req1_ready}, 0);
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, eid);
      chk("rsp_result", rsp_result, eres);
      chk("rsp_err", rsp_err, eerr);
      chk("rsp_readies", {req0_ready, req1_ready}, 0);
      chk("rsp_alu_ctrl", alu_control, 0);
      rsp_ready = (k == stall);
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  typedef struct {
    bit          rst;
    bit          v0, v1;
    logic [11:0] c0; logic [31:0] a0, b0;
    logic [11:0] c1; logic [31:0] a1, b1;
    int          stall;
    bit          eid;
    logic [31:0] eres;
    bit          eerr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_last = 1'b1;

    tbl[0] = '{1, 1, 0, OP_ADD, 32'd5, 32'd7, 12'h0, 32'd0, 32'd0, 0, 0, 32'd12, 0};
    tbl[1] = '{1, 1, 1, OP_SUB, 32'd20, 32'd5, OP_OR, 32'hF0, 32'h0F, 0, 0, 32'd15, 0};
    tbl[2] = '{0, 1, 1, OP_SUB, 32'd20, 32'd5, OP_OR, 32'hF0, 32'h0F, 0, 1, 32'hFF, 0};
    tbl[3] = '{0, 1, 1, OP_SUB, 32'd20, 32'd5, OP_OR, 32'hF0, 32'h0F, 0, 0, 32'd15, 0};
    tbl[4] = '{0, 0, 1, 12'h0, 32'd0, 32'd0, OP_SRA, 32'd4, 32'h8000_0000, 5, 1, 32'hF800_0000, 0};
    tbl[5] = '{0, 1, 0, 12'h0C0, 32'd3, 32'd9, 12'h0, 32'd0, 32'd0, 1, 0, 32'd0, 1};
    tbl[6] = '{0, 1, 0, OP_AND, 32'h0FF0, 32'h3C3C, 12'h0, 32'd0, 32'd0, 0, 0, 32'h0C30, 0};
    tbl[7] = '{0, 0, 1, 12'h0, 32'd0, 32'd0, OP_SLTU, 32'd1, 32'hFFFF_FFFF, 0, 1, 32'd1, 0};
    tbl[8] = '{0, 1, 0, OP_SLT, 32'd1, 32'hFFFF_FFFF, 12'h0, 32'd0, 32'd0, 0, 0, 32'd0, 0};

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      run_op(tbl[i].v0, tbl[i].v1, tbl[i].c0, tbl[i].a0, tbl[i].b0,
             tbl[i].c1, tbl[i].a1, tbl[i].b1, tbl[i].stall,
             tbl[i].eid, tbl[i].eres, tbl[i].eerr);
    end

    // Reset while the op sits in EXEC: aborted, never responded.
    @(negedge clk);
    req0_valid = 1'b1; req0_control = OP_ADD; req0_src1 = 32'd1; req0_src2 = 32'd2;
    #1 chk("abort_req0_ready", req0_ready, 1);
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk("abort_exec_ctrl", alu_control, OP_ADD);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_last = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("abort_alu_ctrl", alu_control, 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_rsp", rsp_valid, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b0;

    // Reset and a valid request in the same cycle: reset wins.
    reset = 1'b1; req0_valid = 1'b1; req0_control = OP_ADD;
    #1 chk("rst_vs_hs_ready", req0_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_inputs();
    m_last = 1'b1;
    @(negedge clk);
    chk("rst_vs_hs_ctrl", alu_control, 0);
    @(negedge clk);
    chk("rst_vs_hs_rsp", rsp_valid, 0);

    // First tie after reset goes to requester FIRST_PRIO = 0.
    run_op(1, 1, OP_ADD, 32'd3, 32'd4, OP_SUB, 32'd9, 32'd1, 0, 0, 32'd7, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 40; i++) begin
      bit v0, v1, eid;
      int idx0, idx1;
      logic [11:0] c0, c1;
      logic [31:0] a0, b0, a1, b1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      idx0 = $urandom_range(0, 13);
      idx1 = $urandom_range(0, 13);
      c0 = (idx0 < 12) ? (12'h001 << idx0) : ((idx0 == 12) ? 12'h0C0 : 12'h000);
      c1 = (idx1 < 12) ? (12'h001 << idx1) : ((idx1 == 12) ? 12'h0C0 : 12'h000);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      eid = (v0 && v1) ? ~m_last : v1;
      run_op(v0, v1, c0, a0, b0, c1, a1, b1, $urandom_range(0, 3), eid,
             eid ? expect_result(c1, a1, b1) : expect_result(c0, a0, b0),
             eid ? ($countones(c1) != 1) : ($countones(c0) != 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
